// File: rtl/pll_ctrl_pkg.sv
// PLL reset controller shared types: FSM state encoding, lock-loss counter
// width and a small helper for sizing the cycle counter.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    localparam int LLC_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync_2ff.sv
// Two-flop synchroniser with async active-low reset (flops clear to 0).
// Ports: i_clk, i_rst_n, i_d (async input), o_q (synchronised output).
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable lock with retry and
// timeout, then releases sys_rst_n. Monitors lock loss and software relock.
// Ports: refclk, rst_n, pll_locked (async), relock_req -> pll_rst, sys_rst_n,
//        ready, fail, lock_loss_cnt[7:0], state[2:0].
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRY           = 3
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             fail,
    output logic [LLC_W-1:0] lock_loss_cnt,
    output logic [2:0]       state
);

    localparam int CW = $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                    LOCK_STABLE_CYCLES)) + 1;
    localparam int RW = $clog2(MAX_RETRY) + 1;

    localparam logic [CW-1:0] PULSE_LAST  = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY - 1);

    logic             w_locked_s;
    state_e           w_state_nx;
    logic [CW-1:0]    w_cnt_nx;
    logic [RW-1:0]    w_retry_nx;
    logic [LLC_W-1:0] w_loss_nx;

    // r_en holds the FSM for one edge after reset release so the first
    // pulse gets its full length of clock cycles.
    logic             r_en;
    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [RW-1:0]    r_retry;
    logic [LLC_W-1:0] r_loss;
    logic             r_pll_rst;
    logic             r_ready;
    logic             r_fail;

    sync_2ff u_sync_locked (
        .i_clk   (refclk),
        .i_rst_n (rst_n),
        .i_d     (pll_locked),
        .o_q     (w_locked_s)
    );

    always_comb begin
        w_state_nx = r_state;
        w_retry_nx = r_retry;
        w_loss_nx  = r_loss;
        if (r_en) begin
            case (r_state)
                ST_RESET_PLL: begin
                    if (r_cnt == PULSE_LAST)
                        w_state_nx = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_state_nx = ST_STABLE;
                    end else if (r_cnt == TO_LAST) begin
                        if (r_retry == RETRY_LAST) begin
                            w_state_nx = ST_FAIL;
                        end else begin
                            w_state_nx = ST_RESET_PLL;
                            w_retry_nx = r_retry + RW'(1);
                        end
                    end
                end
                ST_STABLE: begin
                    if (!w_locked_s) begin
                        w_state_nx = ST_WAIT_LOCK;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_state_nx = ST_RUN;
                        w_retry_nx = '0;
                    end
                end
                ST_RUN: begin
                    // Loss is counted even when relock_req wins below.
                    if (!w_locked_s) begin
                        w_state_nx = ST_RESET_PLL;
                        if (r_loss != '1)
                            w_loss_nx = r_loss + LLC_W'(1);
                    end
                end
                ST_FAIL: ;
                default: w_state_nx = ST_RESET_PLL;
            endcase
            if (relock_req) begin
                w_state_nx = ST_RESET_PLL;
                w_retry_nx = '0;
            end
        end
    end

    // Counter clears on any state change or relock, otherwise saturates.
    always_comb begin
        w_cnt_nx = r_cnt;
        if (r_en) begin
            if (w_state_nx != r_state || relock_req)
                w_cnt_nx = '0;
            else if (r_cnt != '1)
                w_cnt_nx = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_en      <= 1'b0;
            r_state   <= ST_RESET_PLL;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_loss    <= '0;
            r_pll_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_en      <= 1'b1;
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_retry   <= w_retry_nx;
            r_loss    <= w_loss_nx;
            r_pll_rst <= (w_state_nx == ST_RESET_PLL) ||
                         (w_state_nx == ST_FAIL);
            r_ready   <= (w_state_nx == ST_RUN);
            r_fail    <= (w_state_nx == ST_FAIL);
        end
    end

    assign pll_rst       = r_pll_rst;
    assign sys_rst_n     = r_ready;
    assign ready         = r_ready;
    assign fail          = r_fail;
    assign lock_loss_cnt = r_loss;
    assign state         = r_state;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl: table-driven cycle vectors plus
// hand sequences for lock loss, coincident relock and async reset.
module tb_pll_reset_ctrl;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    pll_reset_ctrl #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRY           (2)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .relock_req    (relock_req),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .ready         (ready),
        .fail          (fail),
        .lock_loss_cnt (lock_loss_cnt),
        .state         (state)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct {
        logic       rn;
        logic       lk;
        logic       rq;
        logic [2:0] st;
        logic       prst;
        logic       rdy;
        logic       fl;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input int n, input logic rn, input logic lk,
                                input logic rq, input logic [2:0] st,
                                input logic prst, input logic rdy,
                                input logic fl);
        vec_t v;
        v.rn = rn; v.lk = lk; v.rq = rq;
        v.st = st; v.prst = prst; v.rdy = rdy; v.fl = fl;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_table(input string tag);
        logic [6:0] act;
        logic [6:0] exp;
        for (int i = 0; i < vq.size(); i++) begin
            rst_n      = vq[i].rn;
            pll_locked = vq[i].lk;
            relock_req = vq[i].rq;
            tick();
            act = {state, pll_rst, sys_rst_n, ready, fail};
            exp = {vq[i].st, vq[i].prst, vq[i].rdy, vq[i].rdy, vq[i].fl};
            n_checks++;
            if (act !== exp) begin
                n_errors++;
                $display("FAIL %s row %0d: {st,prst,sys,rdy,fail} got %b expected %b",
                         tag, i, act, exp);
            end
        end
        relock_req = 1'b0;
        vq.delete();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget,
                              input string name);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        chk(name, int'(state), int'(s));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_pll_rst"}, int'(pll_rst), 1);
        chk({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_fail"}, int'(fail), 0);
        chk({tag, "_llc"}, int'(lock_loss_cnt), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_llc;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) tick();
        chk_reset_vals("por");

        // Power-up, relock in RUN, then glitch during STABLE.
        add(4, 1, 0, 0, 3'd0, 1, 0, 0);
        add(6, 1, 0, 0, 3'd1, 0, 0, 0);
        add(2, 1, 1, 0, 3'd1, 0, 0, 0);
        add(8, 1, 1, 0, 3'd2, 0, 0, 0);
        add(2, 1, 1, 0, 3'd3, 0, 1, 0);
        add(1, 1, 1, 1, 3'd0, 1, 0, 0);
        add(3, 1, 1, 0, 3'd0, 1, 0, 0);
        add(1, 1, 1, 0, 3'd1, 0, 0, 0);
        add(5, 1, 1, 0, 3'd2, 0, 0, 0);
        add(2, 1, 0, 0, 3'd2, 0, 0, 0);
        add(1, 1, 0, 0, 3'd1, 0, 0, 0);
        add(2, 1, 1, 0, 3'd1, 0, 0, 0);
        add(8, 1, 1, 0, 3'd2, 0, 0, 0);
        add(2, 1, 1, 0, 3'd3, 0, 1, 0);
        run_table("powerup");
        chk("llc_after_powerup", int'(lock_loss_cnt), 0);

        // relock_req coincident with lock loss seen in RUN.
        pll_locked = 1'b0;
        tick();
        chk("coinc_ready_b0", int'(ready), 1);
        tick();
        chk("coinc_ready_b1", int'(ready), 1);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        pll_locked = 1'b1;
        chk("coinc_state", int'(state), 0);
        chk("coinc_sys_rst_n", int'(sys_rst_n), 0);
        chk("coinc_pll_rst", int'(pll_rst), 1);
        chk("coinc_llc", int'(lock_loss_cnt), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("coinc_pulse", int'(pll_rst), 1);
        end
        tick();
        chk("coinc_pulse_end", int'(pll_rst), 0);
        wait_state(3'd3, 40, "coinc_relock_run");

        // Repeated lock loss in RUN; counter saturates at 255.
        for (int i = 0; i < 257; i++) begin
            pll_locked = 1'b0;
            tick();
            tick();
            chk("loss_sys_before", int'(sys_rst_n), 1);
            tick();
            chk("loss_sys_after", int'(sys_rst_n), 0);
            chk("loss_pll_rst", int'(pll_rst), 1);
            exp_llc = (i + 2 > 255) ? 255 : i + 2;
            chk("loss_llc", int'(lock_loss_cnt), exp_llc);
            pll_locked = 1'b1;
            wait_state(3'd3, 40, "loss_back_to_run");
        end
        chk("llc_saturated", int'(lock_loss_cnt), 255);

        // Async reset while in STABLE.
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        wait_state(3'd2, 40, "reach_stable");
        repeat (2) tick();
        chk("still_stable", int'(state), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        pll_locked = 1'b0;
        tick();
        tick();

        // Lock timeout into FAIL, relock (restarted in RESET_PLL), and a
        // fresh retry budget afterwards.
        add(4, 1, 0, 0, 3'd0, 1, 0, 0);
        add(20, 1, 0, 0, 3'd1, 0, 0, 0);
        add(4, 1, 0, 0, 3'd0, 1, 0, 0);
        add(20, 1, 0, 0, 3'd1, 0, 0, 0);
        add(3, 1, 0, 0, 3'd4, 1, 0, 1);
        add(1, 1, 0, 1, 3'd0, 1, 0, 0);
        add(1, 1, 0, 0, 3'd0, 1, 0, 0);
        add(1, 1, 0, 1, 3'd0, 1, 0, 0);
        add(3, 1, 0, 0, 3'd0, 1, 0, 0);
        add(20, 1, 0, 0, 3'd1, 0, 0, 0);
        add(4, 1, 0, 0, 3'd0, 1, 0, 0);
        add(20, 1, 0, 0, 3'd1, 0, 0, 0);
        add(1, 1, 0, 0, 3'd4, 1, 0, 1);
        run_table("timeout");
        chk("llc_after_timeout", int'(lock_loss_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_ctrl.md
PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16: refclk cycles pll_rst is held high per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 50000: maximum refclk cycles waited for lock after a reset pulse.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive locked cycles required before downstream reset release.
REQ-004 SHALL have parameter MAX_RETRY, default 3: consecutive lock timeouts tolerated before entering FAIL.
REQ-005 SHALL have port refclk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port pll_locked, input, 1: PLL locked indication, asynchronous to refclk.
REQ-008 SHALL have port relock_req, input, 1: single-cycle software request to restart the PLL.
REQ-009 SHALL have port pll_rst, output, 1: active-high reset driven to the PLL rst input.
REQ-010 SHALL have port sys_rst_n, output, 1: active-low reset for logic clocked by outclk_0..2.
REQ-011 SHALL have port ready, output, 1: high while the RUN state is active.
REQ-012 SHALL have port fail, output, 1: high while the FAIL state is active.
REQ-013 SHALL have port lock_loss_cnt, output, 8: count of lock losses seen in RUN, saturating.
REQ-014 SHALL have port state, output, 3: current FSM state encoding.

Function
REQ-015 SHALL synchronise pll_locked through two refclk flops (locked_s); all decisions use locked_s, giving 2-cycle input latency.
REQ-016 SHALL implement states RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4, with a single cycle counter cleared on every state change.
REQ-017 RESET_PLL: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then SHALL go to WAIT_LOCK.
REQ-018 WAIT_LOCK: locked_s=1 SHALL go to STABLE; counter reaching LOCK_TIMEOUT_CYCLES-1 without lock SHALL increment retry_cnt and go to RESET_PLL, or to FAIL when retry_cnt already equals MAX_RETRY-1.
REQ-019 STABLE: locked_s=0 SHALL return to WAIT_LOCK with the counter cleared and retry_cnt unchanged; LOCK_STABLE_CYCLES consecutive locked cycles SHALL go to RUN and clear retry_cnt.
REQ-020 RUN: locked_s=0 SHALL increment lock_loss_cnt (saturating at 255) and go to RESET_PLL.
REQ-021 FAIL: SHALL hold pll_rst=1, and SHALL be left only via relock_req.
REQ-022 relock_req in any state SHALL go to RESET_PLL with counter and retry_cnt cleared, and fail deasserted on the next cycle; in RESET_PLL it restarts the pulse count.
REQ-023 relock_req coincident with lock loss in RUN: relock_req SHALL decide the transition and lock_loss_cnt SHALL still increment.
REQ-024 All outputs SHALL be registered: pll_rst=1 in RESET_PLL/FAIL; sys_rst_n=ready=(state==RUN); fail=(state==FAIL). sys_rst_n falls on the edge the FSM leaves RUN.
REQ-025 Counter width SHALL be $clog2 of the largest cycle parameter plus 1; counters SHALL never wrap.

Reset
REQ-026 rst_n low SHALL asynchronously force state=RESET_PLL, pll_rst=1, sys_rst_n=0, ready=0, fail=0, lock_loss_cnt=0, all counters and retry_cnt=0, sync flops=0.
REQ-027 Release of rst_n SHALL be synchronous to refclk; the first RESET_PLL pulse starts on the first cycle after release.
REQ-028 Reset mid-operation (any state) SHALL abort immediately with the values of REQ-026; lock_loss_cnt is not preserved.

Structure
REQ-029 Package pll_ctrl_pkg SHALL hold the state enumeration/encoding and the lock_loss_cnt width constant.
REQ-030 Sub-module sync_2ff (async-reset two-flop synchroniser) SHALL be instantiated for pll_locked; no other sub-modules.

Verification (bench params RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRY=2)
REQ-031 Power-up: release rst_n, raise pll_locked 10 cycles later -> pll_rst high exactly 4 cycles; ready and sys_rst_n high 2+8 cycles after pll_locked rises, plus 1 cycle for registered outputs.
REQ-032 Glitch in STABLE: drop pll_locked for 3 cycles after 5 locked cycles -> return to WAIT_LOCK, no pll_rst pulse, 8 fresh locked cycles needed before RUN.
REQ-033 Timeout: pll_locked held 0 -> two 4-cycle pll_rst pulses each followed by 20 wait cycles, then state=4 and fail=1 with pll_rst held 1.
REQ-034 Lock loss in RUN, repeated 257 times -> each loss gives sys_rst_n=0 next edge and a new pll_rst pulse; lock_loss_cnt ends at 255.
REQ-035 relock_req in FAIL, and relock_req coincident with lock loss in RUN -> fail clears next cycle, a new 4-cycle pulse starts; in the coincident case lock_loss_cnt increments by 1.
REQ-036 Assert rst_n low during STABLE -> outputs take REQ-026 values without a clock edge.
